cla_subtractor32_seq: RTL and testbench
=======================================

# cla_subtractor32_seq

Multi-cycle 32-bit carry-lookahead subtractor, the inverse operation of the team's 32-bit CLA adder. It computes `sub1_i - sub2_i` one CHUNK-bit slice per cycle, using a lookahead slice fed with the inverted subtrahend and a rippled borrow. It has valid/ready handshakes on both sides, so it drops into the same arithmetic-block test harnesses as the adders. Its result format mirrors the adder: `{borrow, difference}`.

## Interface
Parameters:
- `width`, 32, operand width; must be a multiple of CHUNK.
- `CHUNK`, 8, bits resolved per cycle.
- `APPROX_BITS`, 8, approximated low bits; used only with APPROX_LSB_EN; must be a multiple of CHUNK and less than `width`.

Ports:
- `clk_i`, in, 1, single clock; all state changes on the rising edge.
- `rst_ni`, in, 1, reset; synchronous and active-low.
- `sub1_i`, in, `width`, minuend.
- `sub2_i`, in, `width`, subtrahend.
- `in_valid_i`, in, 1, operands valid.
- `in_ready_o`, out, 1, block can accept operands; high only in IDLE.
- `result_o`, out, `width+1`, `{borrow, diff}`; borrow = 1 when `sub1_i < sub2_i` (unsigned).
- `out_valid_o`, out, 1, result valid.
- `out_ready_i`, in, 1, consumer accepts the result.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready_o` = 1.
  - On `in_valid_i & in_ready_o`: latch both operands, set chunk counter to 0, set borrow register to 0, go to CALC.
- CALC:
  - Each cycle, slice k (bits `k*CHUNK +: CHUNK`) computes `a_k + ~b_k + ~borrow` in the lookahead slice.
  - The slice sum is written into `result_o[k*CHUNK +: CHUNK]`.
  - `borrow` is updated to `~carry_out`.
  - After slice `width/CHUNK-1`: write `result_o[width]` = final borrow, assert `out_valid_o`, go to DONE.
- DONE:
  - `result_o` and `out_valid_o` are held stable until `out_valid_o & out_ready_i`.
  - On that handshake: drop `out_valid_o`, go to IDLE.
  - No operand accept happens in the same cycle.
- Operands are latched at accept. Changes on `sub1_i`/`sub2_i` after accept have no effect.
- Arithmetic: `diff = (sub1 - sub2) mod 2^width`, `borrow = (sub1 < sub2)`. Equal operands give all zeros.
- `in_valid_i` outside IDLE is ignored; the operands are not queued.

## Timing
- Reset (`rst_ni` low at an edge):
  - state IDLE, `result_o` = 0, `out_valid_o` = 0, counter = 0, borrow = 0.
  - `in_ready_o` = 0 while `rst_ni` is low; 1 in the first cycle after release.
- Latency for `width=32`, `CHUNK=8`:
  - Accept edge E0; slices written at edges E1–E4.
  - `out_valid_o` is high after E4, i.e. `width/CHUNK` cycles after accept.
- Minimum initiation interval: `width/CHUNK + 2` cycles (accept, calc, output handshake, return to IDLE).
- Reset asserted in CALC or DONE aborts the operation; no result is ever presented for it.
- `result_o` is valid only while `out_valid_o` is high. Partial slices are visible during CALC and are don't-care.

## Configuration
- Macro: `CLA_SUB_APPROX_LSB_EN`.
- Defined:
  - The low `APPROX_BITS` of diff are `sub1 XOR sub2` of those bits, with no borrow generated.
  - The borrow into the first exact slice is forced to 0.
  - The same cycles are used, so latency is unchanged.
- Undefined: exact subtraction; `APPROX_BITS` is ignored.

## Structure
- Shared package `arith_pkg`:
  - state enum (IDLE/CALC/DONE);
  - default `width`/`CHUNK` constants;
  - `$clog2(width/CHUNK)` counter width helper.
- One sub-module, `cla_slice`: CHUNK-bit generate/propagate lookahead adder with `carry_i` and `carry_o`. It is instantiated once and reused every cycle.

## Test plan
- Reset, then idle: `result_o` = 0, `out_valid_o` = 0 during reset; `in_ready_o` = 1 after release.
- `0x0000_0010 - 0x0000_0001`, exact → `result_o` = `0x0_0000_000F`, valid exactly 4 cycles after accept.
- `0x0000_0000 - 0x0000_0001` → `result_o` = `0x1_FFFF_FFFF` (borrow set); `0x1234_5678 - 0x1234_5678` → 0.
- `out_ready_i` held low 10 cycles → result stable and valid throughout; `in_ready_o` stays 0; new `in_valid_i` ignored.
- `rst_ni` low at 2nd CALC cycle → IDLE, no `out_valid_o`; next operation `0xFFFF_FFFF - 0x8000_0000` = `0x0_7FFF_FFFF`.
- `CLA_SUB_APPROX_LSB_EN`, `APPROX_BITS`=8: `0x0000_0010 - 0x0000_0001` → `0x0_0000_0011`; `0x0000_0100 - 0x0000_0001` → `0x0_0000_0101`.

Source files
------------

// File: rtl/cla_subtractor32_seq_pkg.sv
// Shared arithmetic package: FSM state encoding, default operand geometry
// and the chunk-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_CHUNK = 8;

  // Never returns zero, so a single-chunk build still gets a real counter.
  function automatic int unsigned cnt_width(input int unsigned w, input int unsigned c);
    return (w / c > 1) ? $clog2(w / c) : 1;
  endfunction

endpackage

// File: rtl/cla_subtractor32_seq_if.sv
// Operand/result handshake bundle for cla_subtractor32_seq.
interface cla_subtractor32_seq_if #(
  parameter int unsigned width = 32
) ();

  logic [width-1:0] sub1_i;
  logic [width-1:0] sub2_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [width:0]   result_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    output sub1_i, sub2_i, in_valid_i, out_ready_i,
    input  in_ready_o, result_o, out_valid_o
  );

  modport slave (
    input  sub1_i, sub2_i, in_valid_i, out_ready_i,
    output in_ready_o, result_o, out_valid_o
  );

endinterface

// File: rtl/cla_subtractor32_seq_cla_slice.sv
// CHUNK-bit generate/propagate adder slice with carry in and carry out.
module cla_slice #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             carry_i,
  output logic [CHUNK-1:0] sum,
  output logic             carry_o
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic cy;
    cy   = carry_i;
    c    = '0;
    c[0] = carry_i;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      cy     = g[i] | (p[i] & cy);
      c[i+1] = cy;
    end
  end

  assign sum     = p ^ c[CHUNK-1:0];
  assign carry_o = c[CHUNK];

endmodule

// File: rtl/cla_subtractor32_seq.sv
// Multi-cycle CLA subtractor: one CHUNK-bit slice per cycle, result {borrow, diff}.
// Optional macro CLA_SUB_APPROX_LSB_EN: low APPROX_BITS become sub1 ^ sub2, no borrow.
module cla_subtractor32_seq
  import arith_pkg::*;
#(
  parameter int unsigned width       = DEFAULT_WIDTH,
  parameter int unsigned CHUNK       = DEFAULT_CHUNK,
  parameter int unsigned APPROX_BITS = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  cla_subtractor32_seq_if.slave bus
);

  localparam int unsigned NCHUNK = width / CHUNK;
  localparam int unsigned CW     = cnt_width(width, CHUNK);

  if ((width % CHUNK) != 0 || (APPROX_BITS % CHUNK) != 0 || APPROX_BITS >= width) begin : g_bad_cfg
    $error("cla_subtractor32_seq: invalid width/CHUNK/APPROX_BITS combination");
  end

  state_t           state;
  logic [width-1:0] a_q;
  logic [width-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             borrow_q;
  logic [width:0]   result_q;
  logic             out_valid_q;

  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] b_inv;
  logic [CHUNK-1:0] sum_k;
  logic [CHUNK-1:0] diff_k;
  logic             carry_out;
  logic             borrow_nxt;
  logic             in_ready;
  logic             accept;
  logic             last;

  assign in_ready = rst_ni & (state == IDLE);
  assign accept   = bus.in_valid_i & in_ready;
  assign last     = (cnt == CW'(NCHUNK - 1));

  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        a_k = a_q[k*CHUNK +: CHUNK];
        b_k = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  // a - b == a + ~b + 1; the borrow is carried as the inverted carry.
  assign b_inv = ~b_k;

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a       (a_k),
    .b       (b_inv),
    .carry_i (~borrow_q),
    .sum     (sum_k),
    .carry_o (carry_out)
  );

`ifdef CLA_SUB_APPROX_LSB_EN
  localparam int unsigned NAPPROX = APPROX_BITS / CHUNK;

  always_comb begin
    if (cnt < CW'(NAPPROX)) begin
      diff_k     = a_k ^ b_k;
      borrow_nxt = 1'b0;
    end else begin
      diff_k     = sum_k;
      borrow_nxt = ~carry_out;
    end
  end
`else
  assign diff_k     = sum_k;
  assign borrow_nxt = ~carry_out;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      borrow_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= bus.sub1_i;
            b_q      <= bus.sub2_i;
            cnt      <= '0;
            borrow_q <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) result_q[k*CHUNK +: CHUNK] <= diff_k;
          end
          borrow_q <= borrow_nxt;
          if (last) begin
            result_q[width] <= borrow_nxt;
            out_valid_q     <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.result_o    = result_q;
  assign bus.out_valid_o = out_valid_q;

endmodule

// File: tb/tb_cla_subtractor32_seq.sv
// Self-checking bench for cla_subtractor32_seq (exact build, or approx with CLA_SUB_APPROX_LSB_EN).
module tb_cla_subtractor32_seq;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_subtractor32_seq_if #(.width(32)) bus ();

  cla_subtractor32_seq #(
    .width       (32),
    .CHUNK       (8),
    .APPROX_BITS (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] exp_exact;
    logic [32:0] exp_apx;
  } vec_t;

  vec_t        vecs[8];
  logic [32:0] sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [24:0] hi;
`ifdef CLA_SUB_APPROX_LSB_EN
    hi = {1'b0, a[31:8]} - {1'b0, b[31:8]};
    return {hi, a[7:0] ^ b[7:0]};
`else
    hi = '0;
    return ({1'b0, a} - {1'b0, b}) | {hi, 8'h00};
`endif
  endfunction

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [32:0] exp, input int stall);
    int          cyc;
    logic [32:0] got;
    @(negedge clk);
    check("in_ready_idle", 33'(bus.in_ready_o), 33'd1);
    bus.sub1_i     = a;
    bus.sub2_i     = b;
    bus.in_valid_i = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.sub1_i     = $urandom;
    bus.sub2_i     = $urandom;
    cyc = 0;
    while (!bus.out_valid_o && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", 33'(cyc), 33'(LAT));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      bus.sub1_i     = $urandom;
      bus.sub2_i     = $urandom;
      check("stall_valid", 33'(bus.out_valid_o), 33'd1);
      check("stall_in_ready", 33'(bus.in_ready_o), 33'd0);
      check("stall_result", bus.result_o, exp);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    got = bus.result_o;
    check("out_valid", 33'(bus.out_valid_o), 33'd1);
    if (sb.size() == 0) check("scoreboard_empty", 33'd1, 33'd0);
    else                check("result", got, sb.pop_front());
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    check("valid_dropped", 33'(bus.out_valid_o), 33'd0);
    check("back_to_idle", 33'(bus.in_ready_o), 33'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          seen;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h0000_0010, 32'h0000_0001, 33'h0_0000_000F, 33'h0_0000_0011};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 33'h1_FFFF_FFFF, 33'h0_0000_0001};
    vecs[2] = '{32'h1234_5678, 32'h1234_5678, 33'h0_0000_0000, 33'h0_0000_0000};
    vecs[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 33'h0_7FFF_FFFF, 33'h0_8000_0001};
    vecs[5] = '{32'h0000_0100, 32'h0000_0001, 33'h0_0000_00FF, 33'h0_0000_0101};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF};
    vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 33'h1_0000_0001, 33'h1_0000_01FF};

    rst_n           = 1'b0;
    bus.sub1_i      = '0;
    bus.sub2_i      = '0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_result", bus.result_o, 33'd0);
    check("rst_out_valid", 33'(bus.out_valid_o), 33'd0);
    check("rst_in_ready", 33'(bus.in_ready_o), 33'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 33'(bus.in_ready_o), 33'd1);
    check("post_rst_out_valid", 33'(bus.out_valid_o), 33'd0);

    for (int i = 0; i < 8; i++) begin
`ifdef CLA_SUB_APPROX_LSB_EN
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_apx, (i == 2) ? 10 : 0);
`else
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_exact, (i == 2) ? 10 : 0);
`endif
    end

    // Abort: reset lands on the second CALC cycle, nothing may be presented.
    @(negedge clk);
    bus.sub1_i     = 32'hDEAD_BEEF;
    bus.sub2_i     = 32'h0000_0001;
    bus.in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_out_valid", 33'(bus.out_valid_o), 33'd0);
    check("abort_in_ready", 33'(bus.in_ready_o), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid_o) seen++;
    end
    check("abort_no_result", 33'(seen), 33'd0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, model(32'hFFFF_FFFF, 32'h8000_0000), 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, model(ra, rb), int'($urandom_range(0, 2)));
    end

    check("scoreboard_drained", 33'(sb.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
